// File: rtl/bingo_quad_launch_regs.sv
// bingo_quad_launch_regs: NR_CHANNEL launch channels (doorbell FIFO, launch handshake, done counter, irq) behind one register port
// Optional RUN watchdog is enabled by defining BINGO_QUAD_LAUNCH_TIMEOUT_EN.
// reg_req_i = {addr[31:0], write, wdata[31:0], wstrb[3:0], valid}; reg_rsp_o = {rdata[31:0], error, ready}.
module bingo_quad_launch_regs #(
    parameter int unsigned NR_CHANNEL     = 2,
    parameter int unsigned ADDR_WIDTH     = 48,
    parameter int unsigned REG_WIDTH      = 32,
    parameter int unsigned LAUNCH_DEPTH   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [2*REG_WIDTH+REG_WIDTH/8+1:0] reg_req_i,
    output logic [REG_WIDTH+1:0]             reg_rsp_o,
    output logic [NR_CHANNEL-1:0]            launch_valid_o,
    input  logic [NR_CHANNEL-1:0]            launch_ready_i,
    output logic [NR_CHANNEL*ADDR_WIDTH-1:0] launch_addr_o,
    output logic [NR_CHANNEL*32-1:0]         launch_num_o,
    input  logic [NR_CHANNEL-1:0]            done_i,
    output logic [NR_CHANNEL-1:0]            irq_o
);
    localparam int unsigned PW = $clog2(LAUNCH_DEPTH);
    localparam int unsigned HW = ADDR_WIDTH - 32;
    localparam int unsigned EW = ADDR_WIDTH + 32;
    localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES);
`ifdef BINGO_QUAD_LAUNCH_TIMEOUT_EN
    localparam logic [3:0] IRQ_MASK = 4'hF;
`else
    localparam logic [3:0] IRQ_MASK = 4'h7;
`endif

    typedef enum logic {IDLE, RUN} state_e;

    logic [31:0]  req_addr, req_wdata;
    logic         req_write, req_valid;
    logic [2:0]   ch, rg;
    logic [255:0] rd_all;
    logic [7:0]   db_err, present;
    logic         unused;

    assign req_addr  = reg_req_i[69:38];
    assign req_write = reg_req_i[37];
    assign req_wdata = reg_req_i[36:5];
    assign req_valid = reg_req_i[0];
    assign ch        = req_addr[7:5];
    assign rg        = req_addr[4:2];
    assign unused    = ^{req_addr[31:8], req_addr[1:0], reg_req_i[4:1], TO_LIM};
    assign reg_rsp_o = {req_valid ? rd_all[{ch, 5'b0} +: 32] : 32'h0,
                        req_valid && (!present[ch] || db_err[ch]), req_valid};

    for (genvar c = 0; c < 8; c++) begin : g_ch
        if (c < NR_CHANNEL) begin : g_on
            state_e          state_q, state_d;
            logic [31:0]     base_lo_q, base_lo_d, num_q, num_d, cnt_q, cnt_d, rd;
            logic [HW-1:0]   base_hi_q, base_hi_d;
            logic [3:0]      en_q, en_d, st_q, st_d;
            logic [EW-1:0]   mem_q [LAUNCH_DEPTH];
            logic [EW-1:0]   mem_d [LAUNCH_DEPTH];
            logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d;
            logic [PW:0]     occ_q, occ_d;
            logic [EW-1:0]   head;
            logic            wr, db, full, empty, push, pop, done_ok;
`ifdef BINGO_QUAD_LAUNCH_TIMEOUT_EN
            logic [31:0]     wd_q, wd_d;
`endif
            assign wr                = req_valid && req_write && ch == 3'(c);
            assign db                = wr && rg == 3'd3;
            assign full              = occ_q == (PW+1)'(LAUNCH_DEPTH);
            assign empty             = occ_q == '0;
            assign pop               = state_q == IDLE && !empty && launch_ready_i[c];
            assign push              = db && num_q != '0 && (!full || pop);
            assign done_ok           = state_q == RUN && done_i[c];
            assign head              = mem_q[rp_q];
            assign launch_valid_o[c] = state_q == IDLE && !empty;
            assign launch_addr_o[c*ADDR_WIDTH +: ADDR_WIDTH] = empty ? '0 : head[EW-1:32];
            assign launch_num_o[c*32 +: 32] = empty ? '0 : head[31:0];
            assign irq_o[c]          = |(st_q & en_q);
            assign db_err[c]         = db && num_q == '0;
            assign present[c]        = 1'b1;
            assign rd_all[c*32 +: 32] = rd;

            // software-writable configuration registers
            always_comb begin
                base_lo_d = wr && rg == 3'd0 ? req_wdata : base_lo_q;
                base_hi_d = wr && rg == 3'd1 ? req_wdata[HW-1:0] : base_hi_q;
                num_d     = wr && rg == 3'd2 ? req_wdata : num_q;
                en_d      = wr && rg == 3'd6 ? req_wdata[3:0] & IRQ_MASK : en_q;
            end

            // launch FIFO: a doorbell pushes the current {base, num}, the handshake pops the head
            always_comb begin
                mem_d = mem_q;
                if (push) mem_d[wp_q] = {base_hi_q, base_lo_q, num_q};
                wp_d  = wp_q + PW'(push);
                rp_d  = rp_q + PW'(pop);
                occ_d = occ_q + (PW+1)'(push) - (PW+1)'(pop);
            end

            // channel FSM next state, completion counter and interrupt status (sets beat W1C)
            always_comb begin
                state_d = state_q;
                cnt_d   = wr && rg == 3'd5 ? '0 : cnt_q;
                st_d    = wr && rg == 3'd7 ? st_q & ~req_wdata[3:0] : st_q;
`ifdef BINGO_QUAD_LAUNCH_TIMEOUT_EN
                wd_d    = pop ? '0 : state_q == RUN ? wd_q + 32'd1 : wd_q;
`endif
                if (pop) state_d = RUN;
                if (done_ok) begin
                    state_d = IDLE;
                    cnt_d   = &cnt_d ? cnt_d : cnt_d + 32'd1;
                    st_d[0] = 1'b1;
                end
                if (state_q == IDLE && done_i[c]) st_d[2] = 1'b1;
                if (db && num_q != '0 && full && !pop) st_d[1] = 1'b1;
`ifdef BINGO_QUAD_LAUNCH_TIMEOUT_EN
                if (state_q == RUN && !done_i[c] && wd_q == TO_LIM - 32'd1) begin
                    state_d = IDLE;
                    st_d[3] = 1'b1;
                end
`endif
            end

            // register read-back for this channel
            always_comb begin
                case (rg)
                    3'd0:    rd = base_lo_q;
                    3'd1:    rd = 32'(base_hi_q);
                    3'd2:    rd = num_q;
                    3'd4:    rd = {19'h0, 5'(occ_q), 5'h0, empty, full, state_q == RUN};
                    3'd5:    rd = cnt_q;
                    3'd6:    rd = {28'h0, en_q};
                    3'd7:    rd = {28'h0, st_q};
                    default: rd = '0;
                endcase
            end

            // channel state, cleared by the asynchronous reset (drops queued launches)
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    state_q   <= IDLE;
                    base_lo_q <= '0;
                    base_hi_q <= '0;
                    num_q     <= '0;
                    cnt_q     <= '0;
                    en_q      <= '0;
                    st_q      <= '0;
                    mem_q     <= '{default: '0};
                    wp_q      <= '0;
                    rp_q      <= '0;
                    occ_q     <= '0;
`ifdef BINGO_QUAD_LAUNCH_TIMEOUT_EN
                    wd_q      <= '0;
`endif
                end else begin
                    state_q   <= state_d;
                    base_lo_q <= base_lo_d;
                    base_hi_q <= base_hi_d;
                    num_q     <= num_d;
                    cnt_q     <= cnt_d;
                    en_q      <= en_d;
                    st_q      <= st_d;
                    mem_q     <= mem_d;
                    wp_q      <= wp_d;
                    rp_q      <= rp_d;
                    occ_q     <= occ_d;
`ifdef BINGO_QUAD_LAUNCH_TIMEOUT_EN
                    wd_q      <= wd_d;
`endif
                end
            end
        end else begin : g_off
            assign rd_all[c*32 +: 32] = '0;
            assign db_err[c]          = 1'b0;
            assign present[c]         = 1'b0;
        end
    end
endmodule

// File: tb/tb_bingo_quad_launch_regs.sv
// tb_bingo_quad_launch_regs: scoreboard bench with a queue-based reference model of the launch channels
module tb_bingo_quad_launch_regs;
    localparam int NR = 2;
    localparam int AW = 48;
    localparam int DEP = 4;
    localparam int TO = 16;
`ifdef BINGO_QUAD_LAUNCH_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic [31:0] q_addr = '0, q_wdata = '0;
    logic q_wr = 1'b0, q_valid = 1'b0;
    logic [69:0] req;
    logic [33:0] rsp, last_rsp;
    logic [NR-1:0] lv, lr = '0, dn = '0, irq;
    logic [NR*AW-1:0] la;
    logic [NR*32-1:0] ln;

    always #5 clk = ~clk;
    assign req = {q_addr, q_wr, q_wdata, 4'hF, q_valid};

    bingo_quad_launch_regs #(.NR_CHANNEL(NR), .ADDR_WIDTH(AW), .REG_WIDTH(32),
                             .LAUNCH_DEPTH(DEP), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .reg_req_i(req), .reg_rsp_o(rsp),
        .launch_valid_o(lv), .launch_ready_i(lr), .launch_addr_o(la), .launch_num_o(ln),
        .done_i(dn), .irq_o(irq));

    int n_cmp = 0, n_bad = 0;

    // reference model: per channel register values, pending launch queue, busy flag
    logic [47:0] m_base [NR];
    logic [31:0] m_num [NR], m_cnt [NR];
    logic [3:0]  m_en [NR], m_st [NR];
    bit          m_busy [NR];
    int          m_run [NR];
    logic [79:0] m_fifo [NR][$];
    logic [79:0] exp_l [NR][$];
    logic [33:0] exp_r [$];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void m_reset();
        for (int c = 0; c < NR; c++) begin
            m_base[c] = '0; m_num[c] = '0; m_cnt[c] = '0; m_en[c] = '0; m_st[c] = '0;
            m_busy[c] = 0; m_run[c] = 0;
            m_fifo[c].delete(); exp_l[c].delete();
        end
        exp_r.delete();
    endfunction

    function automatic logic [31:0] m_read(int c, int r);
        int n = m_fifo[c].size();
        case (r)
            0: return m_base[c][31:0];
            1: return {16'h0, m_base[c][47:32]};
            2: return m_num[c];
            4: return {19'h0, 5'(n), 5'h0, n == 0, n == DEP, m_busy[c]};
            5: return m_cnt[c];
            6: return {28'h0, m_en[c]};
            7: return {28'h0, m_st[c]};
            default: return 32'h0;
        endcase
    endfunction

    // advance the model by one clock using the inputs present at that edge
    task automatic step();
        int ch = int'(q_addr[7:5]);
        int rg = int'(q_addr[4:2]);
        for (int c = 0; c < NR; c++) begin
            bit wr, pop;
            logic [3:0] set, st;
            wr = q_valid && q_wr && ch == c;
            pop = !m_busy[c] && m_fifo[c].size() > 0 && lr[c];
            set = '0;
            st = (wr && rg == 7) ? (m_st[c] & ~q_wdata[3:0]) : m_st[c];
            if (wr && rg == 5) m_cnt[c] = '0;
            if (m_busy[c] && dn[c]) begin
                if (m_cnt[c] != 32'hFFFF_FFFF) m_cnt[c]++;
                set[0] = 1'b1;
                m_busy[c] = 0;
            end else if (!m_busy[c] && dn[c]) begin
                set[2] = 1'b1;
            end else if (TMO && m_busy[c]) begin
                m_run[c]++;
                if (m_run[c] == TO) begin
                    m_busy[c] = 0;
                    set[3] = 1'b1;
                end
            end
            if (pop) begin
                void'(m_fifo[c].pop_front());
                m_busy[c] = 1;
                m_run[c] = 0;
            end
            if (wr && rg == 3 && m_num[c] != 0) begin
                if (m_fifo[c].size() < DEP) begin
                    m_fifo[c].push_back({m_base[c], m_num[c]});
                    exp_l[c].push_back({m_base[c], m_num[c]});
                end else set[1] = 1'b1;
            end
            m_st[c] = st | set;
            if (wr && rg == 0) m_base[c][31:0] = q_wdata;
            if (wr && rg == 1) m_base[c][47:32] = q_wdata[15:0];
            if (wr && rg == 2) m_num[c] = q_wdata;
            if (wr && rg == 6) m_en[c] = q_wdata[3:0] & (TMO ? 4'hF : 4'h7);
        end
    endtask

    // one bus cycle: drive, record expected response, clock, update model
    task automatic cyc(input bit v, input logic [31:0] a, input bit w, input logic [31:0] wd);
        int ch = int'(a[7:5]);
        int rg = int'(a[4:2]);
        bit err;
        q_valid = v; q_addr = a; q_wr = w; q_wdata = wd;
        if (v) begin
            if (ch >= NR) exp_r.push_back({!w, 32'h0, 1'b1});
            else begin
                err = w && rg == 3 && m_num[ch] == 0;
                exp_r.push_back({!w, m_read(ch, rg), err});
            end
        end
        #1 last_rsp = rsp;
        @(posedge clk);
        step();
        #1;
        q_valid = 1'b0;
        dn = '0;
    endtask

    // monitor: pops expected responses and launches when the DUT presents them
    always @(negedge clk) begin
        if (rst_ni) begin
            logic [33:0] e;
            logic [79:0] l;
            chk("rsp_ready", rsp[0], q_valid);
            if (rsp[0]) begin
                if (exp_r.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rsp_unexpected: response with empty scoreboard");
                end else begin
                    e = exp_r.pop_front();
                    chk("rsp_err", rsp[1], e[0]);
                    if (e[33]) chk("rsp_rdata", rsp[33:2], e[32:1]);
                end
            end
            for (int c = 0; c < NR; c++) begin
                chk("launch_valid", lv[c], !m_busy[c] && m_fifo[c].size() > 0);
                chk("irq", irq[c], |(m_st[c] & m_en[c]));
                if (lv[c] && lr[c]) begin
                    if (exp_l[c].size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL launch_unexpected: ch%0d launched with empty scoreboard", c);
                    end else begin
                        l = exp_l[c].pop_front();
                        chk("launch_addr", la[c*AW +: AW], l[79:32]);
                        chk("launch_num", ln[c*32 +: 32], l[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", lv, 0);
        chk("rst_addr", la, 0);
        chk("rst_num", ln, 0);
        chk("rst_irq", irq, 0);
        chk("rst_rsp", rsp, 0);
        rst_ni = 1'b1;
        // ch0 launch of base 0x1_0000_2000 / 5 tasks with ready held
        lr = 2'b01;
        cyc(1, 32'h00, 1, 32'h0000_2000);
        cyc(1, 32'h04, 1, 32'h1);
        cyc(1, 32'h08, 1, 32'd5);
        cyc(1, 32'h0C, 1, 0);
        chk("t1_valid", lv[0], 1);
        chk("t1_addr", la[47:0], 48'h1_0000_2000);
        chk("t1_num", ln[31:0], 5);
        cyc(0, 0, 0, 0);
        cyc(1, 32'h10, 0, 0);
        chk("t1_busy", last_rsp[2], 1);
        // completion, interrupt, W1C and clear-vs-done
        cyc(1, 32'h18, 1, 32'h1);
        dn[0] = 1'b1;
        cyc(0, 0, 0, 0);
        chk("t3_irq_set", irq[0], 1);
        cyc(1, 32'h14, 0, 0);
        chk("t3_done_cnt", last_rsp[33:2], 1);
        cyc(1, 32'h1C, 1, 32'h1);
        chk("t3_irq_clr", irq[0], 0);
        cyc(1, 32'h0C, 1, 0);
        cyc(0, 0, 0, 0);
        dn[0] = 1'b1;
        cyc(1, 32'h14, 1, 0);
        cyc(1, 32'h14, 0, 0);
        chk("t3_clr_done", last_rsp[33:2], 1);
        // ch1 overflow with ready low
        lr = 2'b00;
        cyc(1, 32'h28, 1, 32'd3);
        repeat (5) cyc(1, 32'h2C, 1, 0);
        chk("t2_ovf_no_err", last_rsp[1], 0);
        cyc(1, 32'h30, 0, 0);
        chk("t2_status", last_rsp[33:2], 32'h402);
        cyc(1, 32'h3C, 0, 0);
        chk("t2_irq_ovf", last_rsp[33:2], 32'h2);
        // zero task count doorbell and absent channel
        cyc(1, 32'h08, 1, 0);
        cyc(1, 32'h0C, 1, 0);
        chk("t4_db_err", last_rsp[1], 1);
        cyc(1, 32'h10, 0, 0);
        chk("t4_empty", last_rsp[4], 1);
        cyc(1, 32'hE0, 0, 0);
        chk("t4_bad_ch_err", last_rsp[1], 1);
        chk("t4_bad_ch_rdata", last_rsp[33:2], 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r, c, rg;
            bit w;
            logic [31:0] wd;
            lr = 2'($urandom);
            dn[0] = $urandom_range(0, i < 1500 ? 3 : 40) == 0;
            dn[1] = $urandom_range(0, i < 1500 ? 3 : 40) == 0;
            r = $urandom_range(0, 9);
            c = r < 5 ? 0 : r < 9 ? 1 : 7;
            rg = $urandom_range(0, 7);
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                rg = 3;
                w = 1'b1;
            end
            wd = rg == 2 ? 32'($urandom_range(0, 3)) : $urandom;
            cyc(1'($urandom_range(0, 1)), 32'(c * 32 + rg * 4), w, wd);
        end
        // drain everything queued
        lr = 2'b11;
        repeat (40) begin
            dn = 2'b11;
            cyc(0, 0, 0, 0);
        end
        chk("drain_ch0", exp_l[0].size(), 0);
        chk("drain_ch1", exp_l[1].size(), 0);
        chk("drain_rsp", exp_r.size(), 0);
`ifdef BINGO_QUAD_LAUNCH_TIMEOUT_EN
        lr = 2'b00;
        cyc(1, 32'h08, 1, 32'd1);
        cyc(1, 32'h0C, 1, 0);
        lr = 2'b01;
        cyc(0, 0, 0, 0);
        lr = 2'b00;
        repeat (16) cyc(0, 0, 0, 0);
        cyc(1, 32'h10, 0, 0);
        chk("tmo_idle", last_rsp[2], 0);
        cyc(1, 32'h1C, 0, 0);
        chk("tmo_irq", last_rsp[5], 1);
`endif
        // spurious done, then reset in the middle of RUN with launches queued
        rst_ni = 1'b0;
        m_reset();
        @(posedge clk);
        #1 rst_ni = 1'b1;
        lr = 2'b00;
        cyc(1, 32'h08, 1, 32'd2);
        repeat (3) cyc(1, 32'h0C, 1, 0);
        dn[0] = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(1, 32'h1C, 0, 0);
        chk("t5_spurious", last_rsp[4], 1);
        lr = 2'b01;
        cyc(0, 0, 0, 0);
        lr = 2'b00;
        cyc(0, 0, 0, 0);
        #2 rst_ni = 1'b0;
        m_reset();
        #1;
        chk("t5_rst_valid", lv, 0);
        chk("t5_rst_addr", la, 0);
        chk("t5_rst_num", ln, 0);
        chk("t5_rst_irq", irq, 0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        cyc(1, 32'h10, 0, 0);
        chk("t5_status", last_rsp[33:2], 32'h4);
        cyc(0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
